// File: rtl/return_addr_stack.sv
// -----------------------------------------------------------------------------
// return_addr_stack
//
// Hardware return-address stack for the fetch path. A CALL pushes the return
// address (PC+1) and a RET pops it back out to the PC mux. Storage is a
// fixed-depth circular LIFO: pushing while full silently overwrites the oldest
// entry, so the most recent DEPTH call frames always stay predictable.
//
// Ports:
//   clk        system clock, all state changes on the rising edge
//   rst_n      asynchronous active-low reset
//   push       store push_data as the new top (CALL)
//   pop        discard the current top (RET)
//   flush      synchronous clear; wins over push/pop in the same cycle
//   push_data  return address to store
//   top        current top entry, 0 when empty (combinational, no latency)
//   empty      count == 0
//   full       count == DEPTH
//   count      number of valid entries, 0..DEPTH
//   overflow   sticky, set by a push while full
//   underflow  sticky, set by a pop while empty
// -----------------------------------------------------------------------------
module return_addr_stack #(
  parameter  int unsigned DATA_W = 16,
  parameter  int unsigned DEPTH  = 8,
  localparam int unsigned PtrW   = $clog2(DEPTH),
  localparam int unsigned CntW   = PtrW + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic              pop,
  input  logic              flush,
  input  logic [DATA_W-1:0] push_data,
  output logic [DATA_W-1:0] top,
  output logic              empty,
  output logic              full,
  output logic [CntW-1:0]   count,
  output logic              overflow,
  output logic              underflow
);

  localparam logic [CntW-1:0] CntMax = CntW'(DEPTH);
  localparam logic [CntW-1:0] CntOne = CntW'(1);
  localparam logic [PtrW-1:0] PtrOne = PtrW'(1);

  // Storage array is deliberately left out of reset; only entries below
  // count are ever observable on top.
  logic [DATA_W-1:0] r_mem [DEPTH];

  logic [PtrW-1:0] r_sp;
  logic [CntW-1:0] r_cnt;
  logic            r_ovf;
  logic            r_udf;

  logic [PtrW-1:0] w_sp_next;
  logic [CntW-1:0] w_cnt_next;
  logic            w_ovf_next;
  logic            w_udf_next;

  logic            w_empty;
  logic            w_full;
  logic [PtrW-1:0] w_sp_inc;
  logic [PtrW-1:0] w_sp_dec;
  logic            w_mem_we;
  logic [PtrW-1:0] w_mem_waddr;

  assign w_empty  = (r_cnt == '0);
  assign w_full   = (r_cnt == CntMax);
  // Pointer arithmetic wraps naturally because DEPTH is a power of two.
  assign w_sp_inc = r_sp + PtrOne;
  assign w_sp_dec = r_sp - PtrOne;

  // ---------------------------------------------------------------------------
  // Next-state decode
  // ---------------------------------------------------------------------------
  always_comb begin
    w_sp_next   = r_sp;
    w_cnt_next  = r_cnt;
    w_ovf_next  = r_ovf;
    w_udf_next  = r_udf;
    w_mem_we    = 1'b0;
    w_mem_waddr = r_sp;

    if (flush) begin
      w_sp_next  = '0;
      w_cnt_next = '0;
      w_ovf_next = 1'b0;
      w_udf_next = 1'b0;
    end else if (push && pop) begin
      w_mem_we = 1'b1;
      if (!w_empty) begin
        // RET+CALL pair: overwrite the top in place, depth unchanged.
        w_mem_waddr = w_sp_dec;
      end else begin
        // Nothing to return from; the call still lands as a plain push.
        w_sp_next  = w_sp_inc;
        w_cnt_next = CntOne;
        w_udf_next = 1'b1;
      end
    end else if (push) begin
      w_mem_we  = 1'b1;
      w_sp_next = w_sp_inc;
      if (w_full) begin
        // Wrap overwrites the oldest frame; count stays saturated.
        w_ovf_next = 1'b1;
      end else begin
        w_cnt_next = r_cnt + CntOne;
      end
    end else if (pop) begin
      if (w_empty) begin
        w_udf_next = 1'b1;
      end else begin
        w_sp_next  = w_sp_dec;
        w_cnt_next = r_cnt - CntOne;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sp  <= '0;
      r_cnt <= '0;
      r_ovf <= 1'b0;
      r_udf <= 1'b0;
    end else begin
      r_sp  <= w_sp_next;
      r_cnt <= w_cnt_next;
      r_ovf <= w_ovf_next;
      r_udf <= w_udf_next;
    end
  end

  always_ff @(posedge clk) begin
    if (w_mem_we) begin
      r_mem[w_mem_waddr] <= push_data;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign top       = w_empty ? '0 : r_mem[w_sp_dec];
  assign empty     = w_empty;
  assign full      = w_full;
  assign count     = r_cnt;
  assign overflow  = r_ovf;
  assign underflow = r_udf;

endmodule

// File: tb/tb_return_addr_stack.sv
// -----------------------------------------------------------------------------
// tb_return_addr_stack
//
// Self-checking bench for return_addr_stack. A queue-based LIFO model tracks
// the expected stack contents and sticky flags; a negedge process compares
// every DUT output against it each cycle, and directed sequences add literal
// expectations for the documented scenarios before a randomized phase.
// -----------------------------------------------------------------------------
module tb_return_addr_stack;

  localparam int unsigned DATA_W = 16;
  localparam int unsigned DEPTH  = 8;
  localparam int unsigned CNT_W  = 4;

  logic              clk       = 1'b0;
  logic              rst_n     = 1'b0;
  logic              push      = 1'b0;
  logic              pop       = 1'b0;
  logic              flush     = 1'b0;
  logic [DATA_W-1:0] push_data = '0;
  logic [DATA_W-1:0] top;
  logic              empty;
  logic              full;
  logic [CNT_W-1:0]  count;
  logic              overflow;
  logic              underflow;

  int checks = 0;
  int errors = 0;

  // Reference model: back of the queue is the top of stack.
  logic [DATA_W-1:0] m_q[$];
  bit                m_ovf = 1'b0;
  bit                m_udf = 1'b0;

  always #5 clk = ~clk;

  return_addr_stack #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .pop       (pop),
    .flush     (flush),
    .push_data (push_data),
    .top       (top),
    .empty     (empty),
    .full      (full),
    .count     (count),
    .overflow  (overflow),
    .underflow (underflow)
  );

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  function automatic logic [DATA_W-1:0] m_top();
    if (m_q.size() == 0) return '0;
    return m_q[m_q.size()-1];
  endfunction

  task automatic model_reset();
    m_q.delete();
    m_ovf = 1'b0;
    m_udf = 1'b0;
  endtask

  task automatic model_step(input bit p, input bit po, input bit f, input logic [DATA_W-1:0] d);
    if (f) begin
      model_reset();
    end else if (p && po) begin
      if (m_q.size() > 0) begin
        m_q[m_q.size()-1] = d;
      end else begin
        m_q.push_back(d);
        m_udf = 1'b1;
      end
    end else if (p) begin
      m_q.push_back(d);
      if (m_q.size() > int'(DEPTH)) begin
        void'(m_q.pop_front());
        m_ovf = 1'b1;
      end
    end else if (po) begin
      if (m_q.size() > 0) void'(m_q.pop_back());
      else m_udf = 1'b1;
    end
  endtask

  // One operation per call: inputs held across exactly one rising edge.
  task automatic do_op(input bit p, input bit po, input bit f, input logic [DATA_W-1:0] d);
    push      = p;
    pop       = po;
    flush     = f;
    push_data = d;
    @(posedge clk);
    model_step(p, po, f, d);
    #1;
    push  = 1'b0;
    pop   = 1'b0;
    flush = 1'b0;
  endtask

  // Continuous comparison against the model, away from the active edge.
  always @(negedge clk) begin
    check("cmp_top",   32'(top),       32'(m_top()));
    check("cmp_count", 32'(count),     32'(m_q.size()));
    check("cmp_empty", 32'(empty),     32'(m_q.size() == 0));
    check("cmp_full",  32'(full),      32'(m_q.size() == int'(DEPTH)));
    check("cmp_ovf",   32'(overflow),  32'(m_ovf));
    check("cmp_udf",   32'(underflow), 32'(m_udf));
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Reset state
    check("rst_top",   32'(top),       32'h0);
    check("rst_empty", 32'(empty),     32'h1);
    check("rst_full",  32'(full),      32'h0);
    check("rst_count", 32'(count),     32'h0);
    check("rst_ovf",   32'(overflow),  32'h0);
    check("rst_udf",   32'(underflow), 32'h0);

    // Basic push/pop
    do_op(1, 0, 0, 16'h0011);
    do_op(1, 0, 0, 16'h0022);
    do_op(1, 0, 0, 16'h0033);
    check("basic_top",   32'(top),   32'h0033);
    check("basic_count", 32'(count), 32'h3);
    check("basic_empty", 32'(empty), 32'h0);
    check("basic_full",  32'(full),  32'h0);
    do_op(0, 1, 0, '0);
    do_op(0, 1, 0, '0);
    check("basic_pop_top",   32'(top),   32'h0011);
    check("basic_pop_count", 32'(count), 32'h1);

    // Overflow: nine pushes into an 8-deep stack
    do_op(0, 0, 1, '0);
    for (int i = 0; i < 8; i++) do_op(1, 0, 0, 16'(16'h1000 + i));
    check("ovf_full8",  32'(full),     32'h1);
    check("ovf_flag8",  32'(overflow), 32'h0);
    do_op(1, 0, 0, 16'h1008);
    check("ovf_count9", 32'(count),    32'h8);
    check("ovf_flag9",  32'(overflow), 32'h1);
    check("ovf_top9",   32'(top),      32'h1008);
    for (int i = 0; i < 8; i++) begin
      check("ovf_drain_top", 32'(top), 32'(16'h1008 - i));
      do_op(0, 1, 0, '0);
    end
    check("ovf_drain_empty", 32'(empty), 32'h1);
    check("ovf_drain_top0",  32'(top),   32'h0);

    // Underflow
    do_op(0, 0, 1, '0);
    do_op(0, 1, 0, '0);
    check("udf_count", 32'(count),     32'h0);
    check("udf_flag",  32'(underflow), 32'h1);
    check("udf_top",   32'(top),       32'h0);
    do_op(1, 0, 0, 16'h0ABC);
    check("udf_push_top",   32'(top),       32'h0ABC);
    check("udf_push_count", 32'(count),     32'h1);
    check("udf_sticky",     32'(underflow), 32'h1);

    // Push+pop replace and push+pop while empty
    do_op(0, 0, 1, '0);
    do_op(1, 0, 0, 16'h0100);
    do_op(1, 0, 0, 16'h0200);
    do_op(1, 1, 0, 16'h0300);
    check("repl_top",   32'(top),   32'h0300);
    check("repl_count", 32'(count), 32'h2);
    do_op(0, 1, 0, '0);
    check("repl_lower", 32'(top),   32'h0100);
    do_op(0, 0, 1, '0);
    do_op(1, 1, 0, 16'h0400);
    check("repl_empty_count", 32'(count),     32'h1);
    check("repl_empty_top",   32'(top),       32'h0400);
    check("repl_empty_udf",   32'(underflow), 32'h1);

    // Flush beats a simultaneous push
    do_op(0, 0, 1, '0);
    for (int i = 0; i < 9; i++) do_op(1, 0, 0, 16'(16'h2000 + i));
    for (int i = 0; i < 3; i++) do_op(0, 1, 0, '0);
    check("flush_pre_count", 32'(count),    32'h5);
    check("flush_pre_ovf",   32'(overflow), 32'h1);
    do_op(1, 0, 1, 16'h0777);
    check("flush_count", 32'(count),    32'h0);
    check("flush_empty", 32'(empty),    32'h1);
    check("flush_ovf",   32'(overflow), 32'h0);
    check("flush_top",   32'(top),      32'h0);
    do_op(1, 0, 0, 16'h0555);
    check("flush_push_count", 32'(count), 32'h1);
    check("flush_push_top",   32'(top),   32'h0555);

    // Asynchronous reset between edges with a push in flight
    for (int i = 0; i < 3; i++) do_op(1, 0, 0, 16'(16'h3000 + i));
    check("arst_pre_count", 32'(count), 32'h4);
    push      = 1'b1;
    push_data = 16'hDEAD;
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    check("arst_count", 32'(count),     32'h0);
    check("arst_empty", 32'(empty),     32'h1);
    check("arst_top",   32'(top),       32'h0);
    check("arst_ovf",   32'(overflow),  32'h0);
    check("arst_udf",   32'(underflow), 32'h0);
    push = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    do_op(0, 1, 0, '0);
    check("arst_pop_udf",   32'(underflow), 32'h1);
    check("arst_pop_count", 32'(count),     32'h0);

    // Randomized phase
    for (int i = 0; i < 3000; i++) begin
      int r;
      bit p;
      bit po;
      bit f;
      r  = int'($urandom_range(0, 99));
      p  = (r < 40) || (r >= 75 && r < 87);
      po = (r >= 40 && r < 87);
      f  = (r >= 97);
      if (f) p = bit'($urandom_range(0, 1));
      do_op(p, po, f, 16'($urandom));
    end

    @(negedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
